ram_burst_ctrl: RTL and testbench

//  Upstream access sequencer for the single-port MemoriaRAM block. Accepts burst read/write

---
 rtl/ram_burst_ctrl.sv | 132 +++++++++++++
 tb/tb_ram_burst_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: burst access sequencer for a single-port RAM with a combinational read port.
// Accepts read/write burst requests, drives one RAM beat per cycle with an auto-incrementing
// address, and returns read data through a registered valid/ready response stage.
//
// Ports:
//   clk_i, rst_n_i                   clock, asynchronous active-low reset
//   req_valid_i/req_ready_o          request handshake; req_we_i, req_addr_i, req_len_i (beats-1)
//   wdata_valid_i/wdata_ready_o      write beat handshake; wdata_i
//   rsp_valid_o/rsp_ready_i          read beat handshake; rsp_data_o, rsp_last_o (registered)
//   ram_addr_o, ram_rden_o, ram_wren_o, ram_wdata_o, ram_rdata_i   RAM side
//   busy_o                           burst in progress or read beat not yet drained
module ram_burst_ctrl #(
  parameter int unsigned N     = 4,
  parameter int unsigned M     = 4,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [N-1:0]     req_addr_i,
  input  logic [LEN_W-1:0] req_len_i,
  input  logic             wdata_valid_i,
  output logic             wdata_ready_o,
  input  logic [M-1:0]     wdata_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [M-1:0]     rsp_data_o,
  output logic             rsp_last_o,
  output logic [N-1:0]     ram_addr_o,
  output logic             ram_rden_o,
  output logic             ram_wren_o,
  output logic [M-1:0]     ram_wdata_o,
  input  logic [M-1:0]     ram_rdata_i,
  output logic             busy_o
);

  typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     addr_q, addr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [M-1:0]     rsp_data_q, rsp_data_d;
  logic             rsp_last_q, rsp_last_d;

  logic req_fire, wr_fire, issue;

  // No new request is taken while a read beat is still waiting to be drained.
  assign req_fire = (state_q == StIdle) && !rsp_valid_q && req_valid_i;
  assign wr_fire  = (state_q == StWr) && wdata_valid_i;
  // A read is issued only when the response register is free or being emptied this cycle.
  assign issue    = (state_q == StRd) && (!rsp_valid_q || rsp_ready_i);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;

    if (rsp_valid_q && rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (req_fire) begin
          addr_d  = req_addr_i;
          cnt_d   = req_len_i;
          state_d = req_we_i ? StWr : StRd;
        end
      end
      StWr: begin
        if (wr_fire) begin
          addr_d = addr_q + N'(1);
          if (cnt_q == '0) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end
      StRd: begin
        if (issue) begin
          rsp_data_d  = ram_rdata_i;
          rsp_valid_d = 1'b1;
          rsp_last_d  = (cnt_q == '0);
          addr_d      = addr_q + N'(1);
          if (cnt_q == '0) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign req_ready_o   = (state_q == StIdle) && !rsp_valid_q;
  assign wdata_ready_o = (state_q == StWr);
  assign ram_addr_o    = addr_q;
  assign ram_wdata_o   = wdata_i;
  assign ram_wren_o    = wr_fire;
  assign ram_rden_o    = issue;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_last_o    = rsp_last_q;
  assign busy_o        = (state_q != StIdle) || rsp_valid_q;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
module tb_ram_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_we;
  logic [3:0] req_addr, req_len;
  logic       wdata_valid, wdata_ready;
  logic [3:0] wdata;
  logic       rsp_valid, rsp_ready, rsp_last;
  logic [3:0] rsp_data;
  logic [3:0] ram_addr, ram_wdata, ram_rdata;
  logic       ram_rden, ram_wren, busy;

  logic [3:0] mem [16];
  logic       load;
  int         wr_pulses;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  ram_burst_ctrl #(.N(4), .M(4), .LEN_W(4)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_len_i    (req_len),
    .wdata_valid_i(wdata_valid),
    .wdata_ready_o(wdata_ready),
    .wdata_i      (wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .rsp_last_o   (rsp_last),
    .ram_addr_o   (ram_addr),
    .ram_rden_o   (ram_rden),
    .ram_wren_o   (ram_wren),
    .ram_wdata_o  (ram_wdata),
    .ram_rdata_i  (ram_rdata),
    .busy_o       (busy)
  );

  function automatic logic [3:0] init_val(input int i);
    return 4'((i * 3 + 1) & 15);
  endfunction

  // RAM model: synchronous write, combinational read.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
      wr_pulses <= 0;
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_wdata;
      wr_pulses     <= wr_pulses + 1;
    end
  end
  assign ram_rdata = mem[ram_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       mv;
    int         issued, got, cyc;
    logic [3:0] d;

    rst_n = 1'b0; load = 1'b1;
    req_valid = 0; req_we = 0; req_addr = 0; req_len = 0;
    wdata_valid = 0; wdata = 0; rsp_ready = 0;
    tick(); tick();
    load = 1'b0;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rden", 32'(ram_rden), 0);
    chk("rst_wren", 32'(ram_wren), 0);
    chk("rst_wdata_ready", 32'(wdata_ready), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    tick();

    // Write burst with wrap: addr E, 4 beats A..D.
    req_valid = 1; req_we = 1; req_addr = 4'hE; req_len = 4'd3;
    #1 chk("wr_req_ready", 32'(req_ready), 1);
    tick();
    req_valid = 0;
    for (int k = 0; k < 4; k++) begin
      wdata_valid = 1; d = 4'hA + 4'(k); wdata = d;
      #1;
      chk("wr_wdata_ready", 32'(wdata_ready), 1);
      chk("wr_wren", 32'(ram_wren), 1);
      chk("wr_addr", 32'(ram_addr), 32'((14 + k) % 16));
      tick();
    end
    // wdata_valid still high: controller is idle and must not write.
    #1;
    chk("wr_done_wdata_ready", 32'(wdata_ready), 0);
    chk("wr_done_wren", 32'(ram_wren), 0);
    chk("wr_done_busy", 32'(busy), 0);
    tick();
    wdata_valid = 0;
    chk("wr_mem_E", 32'(mem[14]), 32'hA);
    chk("wr_mem_F", 32'(mem[15]), 32'hB);
    chk("wr_mem_0", 32'(mem[0]), 32'hC);
    chk("wr_mem_1", 32'(mem[1]), 32'hD);
    chk("wr_pulses", 32'(wr_pulses), 4);

    // Read burst addr 2, 3 beats, consumer always ready.
    req_valid = 1; req_we = 0; req_addr = 4'd2; req_len = 4'd2; rsp_ready = 1;
    #1 chk("rd_req_ready", 32'(req_ready), 1);
    tick();
    req_valid = 0;
    chk("rd_first_rden", 32'(ram_rden), 1);
    chk("rd_first_addr", 32'(ram_addr), 2);
    chk("rd_first_valid", 32'(rsp_valid), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rd_valid", 32'(rsp_valid), 1);
      chk("rd_data", 32'(rsp_data), 32'(init_val(2 + k)));
      chk("rd_last", 32'(rsp_last), 32'(k == 2));
      chk("rd_rden", 32'(ram_rden), 32'(k < 2));
    end
    tick();
    chk("rd_end_valid", 32'(rsp_valid), 0);
    chk("rd_end_busy", 32'(busy), 0);

    // Read addr 5, 3 beats, consumer ready pattern 1,0,0 repeating.
    req_valid = 1; req_we = 0; req_addr = 4'd5; req_len = 4'd2; rsp_ready = 0;
    tick();
    req_valid = 0;
    mv = 0; issued = 0; got = 0; cyc = 0;
    while (got < 3 && cyc < 20) begin
      rsp_ready = ((cyc % 3) == 0);
      #1;
      chk("stall_rden", 32'(ram_rden), 32'((issued < 3) && (!mv || rsp_ready)));
      chk("stall_valid", 32'(rsp_valid), 32'(mv));
      if ((issued < 3) && (!mv || rsp_ready))
        chk("stall_addr", 32'(ram_addr), 32'(5 + issued));
      if (mv) begin
        chk("stall_data", 32'(rsp_data), 32'(init_val(5 + got)));
        chk("stall_last", 32'(rsp_last), 32'(got == 2));
        if (rsp_ready) got++;
      end
      if ((issued < 3) && (!mv || rsp_ready)) begin
        issued++;
        mv = 1;
      end else if (mv && rsp_ready) begin
        mv = 0;
      end
      cyc++;
      tick();
    end
    chk("stall_beats", 32'(got), 3);
    rsp_ready = 0;
    #1 chk("stall_end_busy", 32'(busy), 0);
    tick();

    // Write addr 8, 2 beats, with a gap in wdata_valid.
    req_valid = 1; req_we = 1; req_addr = 4'd8; req_len = 4'd1;
    tick();
    req_valid = 0;
    wdata_valid = 1; wdata = 4'h3;
    #1 chk("gap_wren0", 32'(ram_wren), 1);
    chk("gap_addr0", 32'(ram_addr), 8);
    tick();
    wdata_valid = 0; wdata = 4'h9;
    #1 chk("gap_wren1", 32'(ram_wren), 0);
    chk("gap_ready1", 32'(wdata_ready), 1);
    tick();
    wdata_valid = 1; wdata = 4'h5;
    #1 chk("gap_wren2", 32'(ram_wren), 1);
    chk("gap_addr2", 32'(ram_addr), 9);
    tick();
    wdata_valid = 0;
    #1 chk("gap_ready3", 32'(wdata_ready), 0);
    tick();
    chk("gap_mem8", 32'(mem[8]), 32'h3);
    chk("gap_mem9", 32'(mem[9]), 32'h5);
    chk("gap_pulses", 32'(wr_pulses), 6);

    // Single-beat read left unconsumed blocks the next request.
    req_valid = 1; req_we = 0; req_addr = 4'd0; req_len = 4'd0; rsp_ready = 0;
    tick();
    req_valid = 0;
    chk("blk_rden", 32'(ram_rden), 1);
    tick();
    chk("blk_valid", 32'(rsp_valid), 1);
    chk("blk_last", 32'(rsp_last), 1);
    chk("blk_data", 32'(rsp_data), 32'hC);
    req_valid = 1; req_addr = 4'd3;
    #1 chk("blk_req_ready0", 32'(req_ready), 0);
    chk("blk_busy", 32'(busy), 1);
    tick();
    chk("blk_req_ready1", 32'(req_ready), 0);
    chk("blk_hold_data", 32'(rsp_data), 32'hC);
    rsp_ready = 1;
    #1 chk("blk_req_ready2", 32'(req_ready), 0);
    tick();
    req_valid = 0; rsp_ready = 0;
    #1 chk("blk_req_ready3", 32'(req_ready), 1);
    chk("blk_valid_clr", 32'(rsp_valid), 0);
    tick();

    // Reset asserted in the middle of a long read burst.
    req_valid = 1; req_we = 0; req_addr = 4'd0; req_len = 4'd7; rsp_ready = 1;
    tick();
    req_valid = 0;
    tick();
    chk("mid_valid", 32'(rsp_valid), 1);
    chk("mid_rden", 32'(ram_rden), 1);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_rden", 32'(ram_rden), 0);
    chk("mid_rst_wren", 32'(ram_wren), 0);
    chk("mid_rst_addr", 32'(ram_addr), 0);
    tick();
    rst_n = 1;
    rsp_ready = 0;
    tick();
    chk("post_rst_req_ready", 32'(req_ready), 1);
    chk("post_rst_busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
